fetch_queue: RTL and testbench

//  Dual-wide instruction fetch stage feeding the Memory block's port 1 and buffering returned words.

---
 rtl/fetch_queue.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Dual-wide instruction fetch stage. Each issue cycle requests two words
//   (pc and pc+4) from a synchronous memory port; the words come back on
//   IR_0/IR_1 one cycle later and are pushed as {pc,instr} pairs into a
//   circular queue. The two oldest entries are presented to dispatch.
//   Fetch issue is credit based: a new pair is only requested when the queue
//   can absorb it together with any pair already in flight, so deq_cnt is
//   never needed to avoid overflow.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   redirect, redirect_pc    flush queue and in-flight fetch, restart fetch
//   ld_haz                   suppress new fetch issue
//   IR_0, IR_1               memory read data (cycle after issue)
//   fetch_pc_0, fetch_pc_1   fetch addresses (pc, pc+4)
//   memRead1                 fetch issue strobe
//   deq_cnt                  entries consumed by dispatch (3 acts as 2)
//   out_valid_*/out_instr_*/out_pc_*   oldest two queue entries
//
// Optional feature (macro FETCH_QUEUE_PERF_EN)
//   perf_issue_cnt  cycles with memRead1 high
//   perf_stall_cnt  cycles blocked by ld_haz or missing credit (no redirect)
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ld_haz,
    input  logic [31:0] IR_0,
    input  logic [31:0] IR_1,
    output logic [31:0] fetch_pc_0,
    output logic [31:0] fetch_pc_1,
    output logic        memRead1,
    input  logic [1:0]  deq_cnt,
    output logic        out_valid_0,
    output logic [31:0] out_instr_0,
    output logic [31:0] out_pc_0,
    output logic        out_valid_1,
    output logic [31:0] out_instr_1,
    output logic [31:0] out_pc_1
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   pc_r;
    logic          pend_r;
    logic [31:0]   pend_pc_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   q_pc_r    [QDEPTH];
    logic [31:0]   q_instr_r [QDEPTH];

    logic [CW+1:0] need_s;
    logic          credit_ok_s;
    logic          issue_s;
    logic          enq_s;
    logic [CW-1:0] deq_req_s;
    logic [CW-1:0] deq_s;
    logic [CW-1:0] count_next_s;
    logic [PW-1:0] rd_ptr_1_s;
    logic [PW-1:0] wr_ptr_1_s;

    // Issue credit, enqueue/dequeue amounts and next occupancy
    always_comb begin
        need_s       = (CW+2)'(count_r) + (CW+2)'(2);
        credit_ok_s  = 1'b0;
        issue_s      = 1'b0;
        enq_s        = 1'b0;
        deq_req_s    = {CW{1'b0}};
        deq_s        = {CW{1'b0}};
        count_next_s = count_r;
        rd_ptr_1_s   = rd_ptr_r + PW'(1);
        wr_ptr_1_s   = wr_ptr_r + PW'(1);

        // an in-flight pair already owns two slots
        if (pend_r) begin
            need_s = need_s + (CW+2)'(2);
        end else begin
            need_s = need_s;
        end
        credit_ok_s = (need_s <= (CW+2)'(QDEPTH));
        issue_s     = !RST && !redirect && !ld_haz && credit_ok_s;
        // the read already happened, so ld_haz does not block the capture
        enq_s       = pend_r && !redirect;

        case (deq_cnt)
            2'd0:    deq_req_s = CW'(0);
            2'd1:    deq_req_s = CW'(1);
            default: deq_req_s = CW'(2);
        endcase

        if (deq_req_s > count_r) begin
            deq_s = count_r;
        end else begin
            deq_s = deq_req_s;
        end

        if (enq_s) begin
            count_next_s = count_r + CW'(2) - deq_s;
        end else begin
            count_next_s = count_r - deq_s;
        end
    end

    // Fetch pc, in-flight tracking, queue pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r      <= RESET_PC;
            pend_r    <= 1'b0;
            pend_pc_r <= RESET_PC;
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
        end else if (redirect) begin
            pc_r     <= {redirect_pc[31:2], 2'b00};
            pend_r   <= 1'b0;
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (issue_s) begin
                pend_r    <= 1'b1;
                pend_pc_r <= pc_r;
                pc_r      <= pc_r + 32'd8;
            end else begin
                pend_r    <= 1'b0;
            end
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(2);
            end
            rd_ptr_r <= rd_ptr_r + PW'(deq_s);
            count_r  <= count_next_s;
        end
    end

    // Queue storage: returned pair written at wr_ptr and wr_ptr+1
    always_ff @(posedge CLK) begin
        if (!RST && enq_s) begin
            q_pc_r[wr_ptr_r]      <= pend_pc_r;
            q_instr_r[wr_ptr_r]   <= IR_0;
            q_pc_r[wr_ptr_1_s]    <= pend_pc_r + 32'd4;
            q_instr_r[wr_ptr_1_s] <= IR_1;
        end
    end

    // Fetch request and dispatch-facing head view
    always_comb begin
        fetch_pc_0  = pc_r;
        fetch_pc_1  = pc_r + 32'd4;
        memRead1    = issue_s;
        out_valid_0 = (count_r >= CW'(1));
        out_valid_1 = (count_r >= CW'(2));
        out_instr_0 = NOP_INSTR;
        out_pc_0    = 32'h0000_0000;
        out_instr_1 = NOP_INSTR;
        out_pc_1    = 32'h0000_0000;
        if (out_valid_0) begin
            out_instr_0 = q_instr_r[rd_ptr_r];
            out_pc_0    = q_pc_r[rd_ptr_r];
        end else begin
            out_instr_0 = NOP_INSTR;
            out_pc_0    = 32'h0000_0000;
        end
        if (out_valid_1) begin
            out_instr_1 = q_instr_r[rd_ptr_1_s];
            out_pc_1    = q_pc_r[rd_ptr_1_s];
        end else begin
            out_instr_1 = NOP_INSTR;
            out_pc_1    = 32'h0000_0000;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // Issue and stall event counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_issue_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (issue_s) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if ((ld_haz || !credit_ok_s) && !redirect) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hF000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ld_haz;
    logic [31:0] IR_0;
    logic [31:0] IR_1;
    logic [31:0] fetch_pc_0;
    logic [31:0] fetch_pc_1;
    logic        memRead1;
    logic [1:0]  deq_cnt;
    logic        out_valid_0;
    logic [31:0] out_instr_0;
    logic [31:0] out_pc_0;
    logic        out_valid_1;
    logic [31:0] out_instr_1;
    logic [31:0] out_pc_1;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] s0;
    logic [31:0] i0;
`endif

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    logic [31:0] sb_q[$];

    always #5 CLK = ~CLK;

    fetch_queue #(.QDEPTH(8), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
        .ld_haz(ld_haz), .IR_0(IR_0), .IR_1(IR_1),
        .fetch_pc_0(fetch_pc_0), .fetch_pc_1(fetch_pc_1), .memRead1(memRead1),
        .deq_cnt(deq_cnt),
        .out_valid_0(out_valid_0), .out_instr_0(out_instr_0), .out_pc_0(out_pc_0),
        .out_valid_1(out_valid_1), .out_instr_1(out_instr_1), .out_pc_1(out_pc_1)
`ifdef FETCH_QUEUE_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Synchronous memory: data is the address XOR KEY, garbage when not read
    always @(posedge CLK) begin
        if (memRead1) begin
            IR_0 <= fetch_pc_0 ^ KEY;
            IR_1 <= fetch_pc_1 ^ KEY;
        end else begin
            IR_0 <= 32'hDEAD_BEEF;
            IR_1 <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input string nm, input logic [31:0] pc, input logic [31:0] instr);
        logic [31:0] e;
        checks++;
        n_pop++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected entry pc=%h", nm, pc);
        end else begin
            e = sb_q.pop_front();
            if (pc !== e || instr !== (e ^ KEY)) begin
                errors++;
                $display("FAIL %s actual pc=%h instr=%h expected pc=%h instr=%h",
                         nm, pc, instr, e, e ^ KEY);
            end
        end
    endtask

    task automatic fill_sb(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(base + 32'(4 * i));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every entry dispatch consumes is checked against the scoreboard
    always @(negedge CLK) begin
        if (!RST && !redirect) begin
            if (deq_cnt >= 2'd1 && out_valid_0) pop_cmp("deq_slot0", out_pc_0, out_instr_0);
            if (deq_cnt >= 2'd2 && out_valid_1) pop_cmp("deq_slot1", out_pc_1, out_instr_1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ld_haz = 1'b0; deq_cnt = 2'd0;
        tick; tick;
        // reset state
        chk("rst_memRead1", 32'(memRead1), 32'd0);
        chk("rst_valid0", 32'(out_valid_0), 32'd0);
        chk("rst_valid1", 32'(out_valid_1), 32'd0);
        chk("rst_fetch_pc_0", fetch_pc_0, 32'h0);
        RST = 1'b0; #1;
        chk("c0_memRead1", 32'(memRead1), 32'd1);
        chk("c0_fetch_pc_0", fetch_pc_0, 32'h0);
        chk("c0_fetch_pc_1", fetch_pc_1, 32'h4);
        fill_sb(32'h0, 64);

        // fill with no dequeue: credit allows four pairs, then issue stops
        tick;
        chk("c1_memRead1", 32'(memRead1), 32'd1);
        chk("c1_fetch_pc_0", fetch_pc_0, 32'h8);
        chk("c1_valid0", 32'(out_valid_0), 32'd0);
        tick;
        chk("c2_memRead1", 32'(memRead1), 32'd1);
        chk("c2_fetch_pc_0", fetch_pc_0, 32'h10);
        chk("c2_valid0", 32'(out_valid_0), 32'd1);
        chk("c2_out_pc_0", out_pc_0, 32'h0);
        tick;
        chk("c3_memRead1", 32'(memRead1), 32'd1);
        chk("c3_fetch_pc_0", fetch_pc_0, 32'h18);
        tick;
        chk("c4_memRead1", 32'(memRead1), 32'd0);
        chk("c4_fetch_pc_0", fetch_pc_0, 32'h20);
        tick;
        chk("c5_memRead1", 32'(memRead1), 32'd0);
        chk("c5_fetch_pc_0", fetch_pc_0, 32'h20);
        chk("c5_valid1", 32'(out_valid_1), 32'd1);
        chk("c5_out_pc_0", out_pc_0, 32'h0);
        chk("c5_out_instr_0", out_instr_0, KEY);
        chk("c5_out_pc_1", out_pc_1, 32'h4);
        chk("c5_out_instr_1", out_instr_1, 32'h4 ^ KEY);

        // steady dequeue of two per cycle, then deq_cnt=3 acting as 2
        deq_cnt = 2'd2;
        for (int i = 0; i < 10; i++) tick;
        deq_cnt = 2'd3;
        for (int i = 0; i < 6; i++) tick;
        chk("throughput_ge28", 32'(n_pop >= 28), 32'd1);
        chk("steady_memRead1", 32'(memRead1), 32'd1);

        // redirect to 0x103 with a fetch in flight
        tick;
        redirect = 1'b1; redirect_pc = 32'h0000_0103; deq_cnt = 2'd2;
        sb_q.delete();
        fill_sb(32'h100, 64);
        #1;
        chk("redir_memRead1", 32'(memRead1), 32'd0);
        tick;
        redirect = 1'b0; deq_cnt = 2'd0; #1;
        chk("redir1_fetch_pc_0", fetch_pc_0, 32'h100);
        chk("redir1_memRead1", 32'(memRead1), 32'd1);
        chk("redir1_valid0", 32'(out_valid_0), 32'd0);
        tick;
        chk("redir2_valid0", 32'(out_valid_0), 32'd0);
        chk("redir2_fetch_pc_0", fetch_pc_0, 32'h108);
        tick;
        chk("redir3_valid0", 32'(out_valid_0), 32'd1);
        chk("redir3_out_pc_0", out_pc_0, 32'h100);
        chk("redir3_out_instr_0", out_instr_0, 32'h100 ^ KEY);
        chk("redir3_out_pc_1", out_pc_1, 32'h104);
        deq_cnt = 2'd2;

        // load hazard for three cycles right after an issue
        tick;
        chk("haz0_memRead1", 32'(memRead1), 32'd1);
        chk("haz0_fetch_pc_0", fetch_pc_0, 32'h118);
        tick;
        ld_haz = 1'b1;
`ifdef FETCH_QUEUE_PERF_EN
        s0 = perf_stall_cnt;
        i0 = perf_issue_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("haz_memRead1", 32'(memRead1), 32'd0);
            chk("haz_pc_held", fetch_pc_0, 32'h120);
            tick;
        end
        ld_haz = 1'b0; deq_cnt = 2'd0; #1;
        chk("haz_end_memRead1", 32'(memRead1), 32'd1);
        chk("haz_end_fetch_pc_0", fetch_pc_0, 32'h120);
        chk("haz_end_valid0", 32'(out_valid_0), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_stall_delta", perf_stall_cnt - s0, 32'd3);
        chk("perf_issue_delta", perf_issue_cnt - i0, 32'd0);
`endif

        // count=1 with deq_cnt=2 removes only one entry
        tick;
        ld_haz = 1'b1; #1;
        chk("one_memRead1", 32'(memRead1), 32'd0);
        chk("one_valid0_pre", 32'(out_valid_0), 32'd0);
        tick;
        chk("one_valid1_two", 32'(out_valid_1), 32'd1);
        chk("one_out_pc_0_two", out_pc_0, 32'h120);
        deq_cnt = 2'd1;
        tick;
        chk("one_valid0", 32'(out_valid_0), 32'd1);
        chk("one_valid1", 32'(out_valid_1), 32'd0);
        chk("one_out_pc_0", out_pc_0, 32'h124);
        chk("one_out_pc_1_inv", out_pc_1, 32'h0);
        chk("one_out_instr_1_nop", out_instr_1, NOP);
        deq_cnt = 2'd2;
        tick;
        chk("empty_valid0", 32'(out_valid_0), 32'd0);
        chk("empty_valid1", 32'(out_valid_1), 32'd0);
        chk("empty_out_pc_0", out_pc_0, 32'h0);
        chk("empty_out_instr_0", out_instr_0, NOP);
        deq_cnt = 2'd0;
        tick;
        ld_haz = 1'b0; #1;
        chk("resume_valid0", 32'(out_valid_0), 32'd0);
        chk("resume_memRead1", 32'(memRead1), 32'd1);
        chk("resume_fetch_pc_0", fetch_pc_0, 32'h128);
        tick; tick;
        chk("resume_out_pc_0", out_pc_0, 32'h128);
        deq_cnt = 2'd2;

        // reset in the middle of operation drops the in-flight return
        tick;
        RST = 1'b1;
        sb_q.delete();
        fill_sb(32'h0, 64);
        #1;
        chk("mrst_memRead1", 32'(memRead1), 32'd0);
        tick;
        RST = 1'b0; #1;
        chk("mrst_fetch_pc_0", fetch_pc_0, 32'h0);
        chk("mrst_memRead1_after", 32'(memRead1), 32'd1);
        chk("mrst_valid0", 32'(out_valid_0), 32'd0);
        tick;
        chk("mrst2_valid0", 32'(out_valid_0), 32'd0);
        tick;
        chk("mrst3_valid0", 32'(out_valid_0), 32'd1);
        chk("mrst3_out_pc_0", out_pc_0, 32'h0);
        for (int i = 0; i < 6; i++) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
